// File: rtl/trigger_pkg.sv
// Shared types and defaults for the trigger capture path: FSM state encoding,
// PCM sample width and the default capture geometry.
package trigger_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    READ      = 3'd4
  } state_t;

  localparam int PCM_W               = 16;
  localparam int DEPTH_DEFAULT       = 256;
  localparam int PRE_SAMPLES_DEFAULT = 64;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port and one registered read port,
// both on pcm_clk. The read register holds its value while rd_en is low.
module capture_ram
  import trigger_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    pcm_clk,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic signed [PCM_W-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic signed [PCM_W-1:0] rd_data
);

  logic signed [PCM_W-1:0] mem [DEPTH];

  always_ff @(posedge pcm_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trigger_capture.sv
// Trigger-driven circular PCM capture with pre-trigger history and an
// oldest-first valid/ready readout. Define TRIGGER_CAPTURE_AUTO_REARM_EN to re-arm after readout.
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int PRE_SAMPLES = PRE_SAMPLES_DEFAULT,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                    pcm_clk,
  input  logic                    reset,
  input  logic signed [PCM_W-1:0] pcm,
  input  logic                    trigger,
  input  logic                    arm,
  output logic signed [PCM_W-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_W-1:0] FILL_LAST   = ADDR_W'(PRE_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] POST_INIT   = ADDR_W'(DEPTH - PRE_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] PRE_OFFSET  = ADDR_W'(PRE_SAMPLES);
  localparam logic [ADDR_W:0]   ISSUE_LAST  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   ISSUE_TOTAL = (ADDR_W + 1)'(DEPTH);

  state_t                  state;
  logic [ADDR_W-1:0]       wr_ptr;
  logic [ADDR_W-1:0]       fill_cnt;
  logic [ADDR_W-1:0]       post_cnt;
  logic [ADDR_W-1:0]       trig_addr;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [ADDR_W:0]         issue_cnt;
  logic                    ram_vld;
  logic                    ram_last;
  logic signed [PCM_W-1:0] ram_q;

  logic wr_en;
  logic move;
  logic rd_en;
  logic beat;

  // RAM output register acts as a one-deep prefetch stage in front of the
  // output register, so a stalled reader simply freezes both stages.
  always_comb begin
    wr_en = (state == FILL) || (state == WAIT_TRIG) || (state == POST);
    beat  = rd_valid && rd_ready;
    move  = ram_vld && (!rd_valid || rd_ready);
    rd_en = (state == READ) && (issue_cnt != ISSUE_TOTAL) && (!ram_vld || move);
  end

  capture_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .pcm_clk (pcm_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (pcm),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_ff @(posedge pcm_clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      trig_addr <= '0;
      rd_ptr    <= '0;
      issue_cnt <= '0;
      ram_vld   <= 1'b0;
      ram_last  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= FILL;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        FILL: begin
          wr_ptr   <= wr_ptr + 1'b1;
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == FILL_LAST) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (trigger) begin
            trig_addr <= wr_ptr;
            post_cnt  <= POST_INIT;
            issue_cnt <= '0;
            rd_ptr    <= wr_ptr - PRE_OFFSET;
            // With PRE_SAMPLES = DEPTH-1 the trigger sample already completes the window.
            state     <= (POST_INIT == '0) ? READ : POST;
          end
        end
        POST: begin
          wr_ptr   <= wr_ptr + 1'b1;
          post_cnt <= post_cnt - 1'b1;
          if (post_cnt == ADDR_W'(1)) begin
            state  <= READ;
            rd_ptr <= trig_addr - PRE_OFFSET;
          end
        end
        READ: begin
          if (rd_en) begin
            rd_ptr    <= rd_ptr + 1'b1;
            issue_cnt <= issue_cnt + 1'b1;
            ram_last  <= (issue_cnt == ISSUE_LAST);
            ram_vld   <= 1'b1;
          end else if (move) begin
            ram_vld <= 1'b0;
          end
          if (move) begin
            rd_data  <= ram_q;
            rd_last  <= ram_last;
            rd_valid <= 1'b1;
          end else if (beat) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
          if (beat && rd_last) begin
            done <= 1'b1;
`ifdef TRIGGER_CAPTURE_AUTO_REARM_EN
            state    <= FILL;
            wr_ptr   <= '0;
            fill_cnt <= '0;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture with DEPTH=16, PRE_SAMPLES=4 and
// pcm equal to the cycle index since arm.
module tb_trigger_capture;

  logic               pcm_clk = 1'b0;
  logic               reset;
  logic signed [15:0] pcm;
  logic               trigger;
  logic               arm;
  logic signed [15:0] rd_data;
  logic               rd_valid;
  logic               rd_ready;
  logic               rd_last;
  logic               busy;
  logic               done;

  int tests     = 0;
  int fails     = 0;
  int idx       = 0;
  int trig_at   = -1;
  bit trig_hold = 1'b0;
  int lat;

  always #5 pcm_clk = ~pcm_clk;

  trigger_capture #(
    .DEPTH       (16),
    .PRE_SAMPLES (4)
  ) dut (
    .pcm_clk  (pcm_clk),
    .reset    (reset),
    .pcm      (pcm),
    .trigger  (trigger),
    .arm      (arm),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pcm_clk);
    #1;
    idx++;
    pcm     = 16'(idx);
    trigger = trig_hold || (idx == trig_at);
  endtask

  task automatic do_arm();
`ifdef TRIGGER_CAPTURE_AUTO_REARM_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
    arm = 1'b1;
    @(posedge pcm_clk);
    #1;
    arm     = 1'b0;
    idx     = 0;
    pcm     = 16'sd0;
    trigger = trig_hold || (trig_at == 0);
  endtask

  // Drains one window, checking order, rd_last, stall stability and done/busy.
  task automatic read_window(input int first, input bit toggle, input int next_trig);
    int   got       = 0;
    int   cyc       = 0;
    bit   phase     = 1'b1;
    bit   prev_stall = 1'b0;
    logic [15:0] held_data = '0;
    logic        held_last = 1'b0;
    while (got < 16 && cyc < 300) begin
      rd_ready = toggle ? phase : 1'b1;
      phase    = !phase;
      if (prev_stall) begin
        check("stall_data", rd_data, held_data);
        check("stall_last", rd_last, held_last);
      end
      if (rd_valid && rd_ready) begin
        check("beat_data", rd_data, first + got);
        check("beat_last", rd_last, (got == 15) ? 1 : 0);
        $display("[TB] beat %0d data=%0d last=%0b", got, rd_data, rd_last);
        got++;
      end
      prev_stall = rd_valid && !rd_ready;
      held_data  = rd_data;
      held_last  = rd_last;
      tick();
      cyc++;
    end
    check("beat_count", got, 16);
    check("done_pulse", done, 1);
`ifdef TRIGGER_CAPTURE_AUTO_REARM_EN
    check("busy_rearm", busy, 1);
    idx     = 0;
    pcm     = 16'sd0;
    trig_at = next_trig;
    trigger = (trig_at == 0);
`else
    check("busy_fall", busy, 0);
    trig_at = next_trig;
`endif
    tick();
    check("done_once", done, 0);
  endtask

  initial begin
    reset    = 1'b1;
    arm      = 1'b0;
    trigger  = 1'b0;
    rd_ready = 1'b0;
    pcm      = 16'sd0;

    repeat (3) tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_rd_valid", rd_valid, 0);
    end
    check("idle_busy", busy, 0);

    // Trigger first at pcm=20.
    rd_ready = 1'b1;
    trig_at  = 20;
    do_arm();
    check("busy_armed", busy, 1);
`ifdef TRIGGER_CAPTURE_AUTO_REARM_EN
    read_window(16, 1'b0, 6);
    read_window(2, 1'b0, -1);
`else
    read_window(16, 1'b0, -1);
`endif

    // Trigger held from arm: FILL ignores it, window is 0..15.
    trig_hold = 1'b1;
    trig_at   = -1;
    rd_ready  = 1'b1;
    do_arm();
    lat = 0;
    while (!rd_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("read_latency", lat, 18);
    trig_hold = 1'b0;
    read_window(0, 1'b0, -1);

    // Backpressure with rd_ready toggling.
    trig_at = 20;
    do_arm();
    read_window(16, 1'b1, -1);

    // Reset during POST, then a fresh capture.
    trig_at = 8;
    rd_ready = 1'b1;
    do_arm();
    while (idx < 15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_done", done, 0);
    trig_at = 9;
    do_arm();
    read_window(5, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Trigger-driven PCM capture buffer that consumes the `triggered` level from the threshold trigger. Once armed, it continuously records the PCM stream into a circular buffer. It keeps a fixed pre-trigger history and fills the rest of the buffer after the trigger. It then streams the frozen window out oldest-first over a valid/ready read port to the host/readout logic.

## Interface
- `DEPTH`, 256, capture window in samples; power of two, ≥ 4
- `PRE_SAMPLES`, 64, pre-trigger samples kept; 1 ≤ PRE_SAMPLES < DEPTH
- `ADDR_W`, $clog2(DEPTH), buffer address width (derived; do not override)
- `pcm_clk`  in  1  sample clock; one PCM sample per rising edge
- `reset`  in  1  synchronous, active-high
- `pcm`  in  16  signed PCM sample, sampled every pcm_clk
- `trigger`  in  1  level from threshold trigger
- `arm`  in  1  start a capture; honoured only in IDLE
- `rd_data`  out  16  signed captured sample
- `rd_valid`  out  1  rd_data valid
- `rd_ready`  in  1  reader accepts rd_data
- `rd_last`  out  1  qualifies final sample of window
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after last sample accepted

## Operation
- States: IDLE, FILL, WAIT_TRIG, POST, READ.
- IDLE: no writes. `arm` → FILL with wr_ptr=0 and fill_cnt=0.
- FILL: write `pcm` at wr_ptr each cycle, wr_ptr++. `trigger` is ignored. After PRE_SAMPLES writes → WAIT_TRIG.
- WAIT_TRIG: write every cycle with wr_ptr wrapping mod DEPTH. On the first cycle with `trigger`=1:
  - latch trig_addr=wr_ptr; that cycle's sample is post-sample #1;
  - post_cnt=DEPTH−PRE_SAMPLES−1;
  - → POST.
- POST: write every cycle, decrementing post_cnt. The write with post_cnt=0 is the last write → READ. The last written address is trig_addr+DEPTH−PRE_SAMPLES−1, so pre-trigger history is never overwritten.
- READ: no writes. rd_ptr starts at (trig_addr−PRE_SAMPLES) mod DEPTH. Exactly DEPTH samples are delivered in write order. `rd_last` is high with sample DEPTH−1.
- After the last beat is accepted: `done` pulses and the block returns to IDLE (see Configuration).
- Handshake: a beat transfers when rd_valid&rd_ready. rd_data and rd_last are held stable while rd_valid&!rd_ready. No beats are dropped or duplicated.
- Ignored inputs: `arm` outside IDLE; `trigger` outside WAIT_TRIG.
- Reset values: state IDLE, all pointers and counters 0, rd_data=0, rd_valid=0, rd_last=0, busy=0, done=0.
- Reset in any state aborts the capture; buffer contents are don't-care.

## Timing
- One write per cycle in FILL/WAIT_TRIG/POST, with no gaps.
- Samples are written on the same edge they are sampled.
- READ is entered on the edge after the final POST write.
- rd_valid rises exactly 2 cycles after entering READ (registered RAM read plus output register).
- Sustained throughput: 1 beat/cycle while rd_ready=1.
- `done` is asserted the cycle after the last beat transfers, for exactly one cycle. busy falls in the same cycle.
- Minimum arm-to-READ: PRE_SAMPLES+DEPTH−PRE_SAMPLES = DEPTH cycles, reached when trigger is high on the first WAIT_TRIG cycle.

## Configuration
- `TRIGGER_CAPTURE_AUTO_REARM_EN` defined: after the last beat the block goes directly to FILL, not IDLE. `done` still pulses, busy stays high, and `arm` has no further effect.
- Undefined: return to IDLE; a new `arm` is required.

## Structure
- Shared package `trigger_pkg`:
  - state encoding (IDLE=0, FILL=1, WAIT_TRIG=2, POST=3, READ=4; 3 bits);
  - PCM width constant (16);
  - DEPTH/PRE_SAMPLES defaults, shared with `threshold_trigger` users.
- One sub-module, `capture_ram`: simple dual-port RAM, DEPTH×16, write port plus registered synchronous read port, both on pcm_clk.
- FSM, pointers and handshake output register live in `trigger_capture`.

## Test plan
All cases use DEPTH=16 and PRE_SAMPLES=4, with pcm = cycle index since arm (0,1,2,…).
- Reset held 3 cycles → all outputs 0, busy=0. rd_valid stays 0 for 20 cycles without arm.
- Arm, trigger=1 first when pcm=20 → readout 16..31 in order; rd_last only on 31; done pulses once; busy falls.
- Trigger held high from arm → FILL ignores it; trigger sample is pcm=4; readout 0..15; READ entered 16 cycles after arm.
- Trigger at pcm=20, rd_ready toggles 1,0,1,0 → readout 16..31 with no duplicates or gaps; rd_data stable during stalls.
- Reset asserted in POST (post_cnt=5) → next cycle IDLE, busy=0, rd_valid=0. Re-arm with trigger at pcm=9 → readout 5..20 correct.
- With `TRIGGER_CAPTURE_AUTO_REARM_EN`: after the done pulse the block is in FILL; a second trigger yields a second correct 16-sample window without arm.
